// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Holds the fetch PC, presents it to a
//   combinational instruction memory and drives the IF/ID producer signals.
//   An optional direct-mapped BHT/BTB predicts taken branches at pc_f.
//
// Configuration macro:
//   BRANCH_PREDICT_EN  defined   -> BHT/BTB built, trained by update_* inputs
//                      undefined -> no tables, predicted_branch_f = 0,
//                                   update_* inputs ignored
//
// Parameters:
//   RESET_PC     PC loaded while rst is low
//   BHT_ENTRIES  predictor entries (power of two, >= 2)
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   stall_f             hold the PC this cycle
//   redirect_e          refetch from redirect_pc_e (beats stall_f)
//   redirect_pc_e       redirect target
//   update_en_e         train predictor with a resolved branch
//   update_pc_e         PC of the resolved branch
//   update_taken_e      resolved direction
//   update_target_e     resolved taken target
//   imem_addr           instruction memory address (= pc_f)
//   imem_rdata          instruction memory read data (combinational)
//   pc_f                current fetch PC
//   pc_plus4_f          pc_f + 4 (mod 2^32)
//   instruction_f       = imem_rdata
//   predicted_branch_f  predictor says taken for pc_f
//   flush_f             clear IF/ID on next edge (= redirect_e)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        redirect_e,
    input  logic [31:0] redirect_pc_e,
    input  logic        update_en_e,
    input  logic [31:0] update_pc_e,
    input  logic        update_taken_e,
    input  logic [31:0] update_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic [31:0] instruction_f,
    output logic        predicted_branch_f,
    output logic        flush_f
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        predict_taken;
    logic [31:0] predict_target;

    assign pc_plus4 = pc + 32'd4;

`ifdef BRANCH_PREDICT_EN
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic             valid   [BHT_ENTRIES];
    logic [TAG_W-1:0] tag_mem [BHT_ENTRIES];
    logic [1:0]       cnt     [BHT_ENTRIES];
    logic [31:0]      tgt     [BHT_ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             unused_upd_lsb;

    assign look_idx = pc[IDX_W+1:2];
    assign look_tag = pc[31:IDX_W+2];
    assign upd_idx  = update_pc_e[IDX_W+1:2];
    assign upd_tag  = update_pc_e[31:IDX_W+2];
    assign upd_hit  = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    assign unused_upd_lsb = ^update_pc_e[1:0];

    // Lookup reads the registered tables, so a same-cycle update to the
    // looked-up index only becomes visible on the following cycle.
    assign predict_taken  = valid[look_idx] && (tag_mem[look_idx] == look_tag)
                            && cnt[look_idx][1];
    assign predict_target = tgt[look_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tag_mem[i] <= '0;
                cnt[i]     <= 2'b01;
                tgt[i]     <= '0;
            end
        end else if (update_en_e) begin
            if (upd_hit) begin
                if (update_taken_e) begin
                    if (cnt[upd_idx] != 2'b11) begin
                        cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
                    end
                end else begin
                    if (cnt[upd_idx] != 2'b00) begin
                        cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
                    end
                end
            end else begin
                valid[upd_idx]   <= 1'b1;
                tag_mem[upd_idx] <= upd_tag;
                cnt[upd_idx]     <= update_taken_e ? 2'b10 : 2'b01;
            end
            if (update_taken_e) begin
                tgt[upd_idx] <= update_target_e;
            end
        end
    end
`else
    logic unused_update;

    assign unused_update  = ^{update_en_e, update_pc_e, update_taken_e, update_target_e};
    assign predict_taken  = 1'b0;
    assign predict_target = pc_plus4;
`endif

    always_comb begin
        pc_next = pc_plus4;
        if (redirect_e) begin
            pc_next = redirect_pc_e;
        end else if (stall_f) begin
            pc_next = pc;
        end else if (predict_taken) begin
            pc_next = predict_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign imem_addr          = pc;
    assign pc_f               = pc;
    assign pc_plus4_f         = pc_plus4;
    assign instruction_f      = imem_rdata;
    assign predicted_branch_f = predict_taken;
    assign flush_f            = redirect_e;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model (PC plus a
//   per-index predictor table) is compared against the DUT every cycle;
//   directed sequences with literal expectations pin the model, then a
//   randomized phase exercises stall/redirect/update interactions.
//   Follows BRANCH_PREDICT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned BHT      = 16;
`ifdef BRANCH_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;
    logic        update_en_e;
    logic [31:0] update_pc_e;
    logic        update_taken_e;
    logic [31:0] update_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [31:0] instruction_f;
    logic        predicted_branch_f;
    logic        flush_f;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .BHT_ENTRIES(BHT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_f           (stall_f),
        .redirect_e        (redirect_e),
        .redirect_pc_e     (redirect_pc_e),
        .update_en_e       (update_en_e),
        .update_pc_e       (update_pc_e),
        .update_taken_e    (update_taken_e),
        .update_target_e   (update_target_e),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .pc_f              (pc_f),
        .pc_plus4_f        (pc_plus4_f),
        .instruction_f     (instruction_f),
        .predicted_branch_f(predicted_branch_f),
        .flush_f           (flush_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mpc;
    bit          mval [BHT];
    logic [31:0] mtag [BHT];
    int          mcnt [BHT];
    logic [31:0] mtgt [BHT];

    function automatic int unsigned idx_of(input logic [31:0] p);
        return (p / 4) % BHT;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] p);
        return p / (4 * BHT);
    endfunction

    function automatic bit model_pred(input logic [31:0] p);
        int unsigned i;
        i = idx_of(p);
        return PRED && mval[i] && (mtag[i] == tag_of(p)) && (mcnt[i] >= 2);
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int unsigned ui;
        logic [31:0] nxt;
        if (!rst) begin
            mpc <= RESET_PC;
            for (int i = 0; i < BHT; i++) begin
                mval[i] <= 1'b0;
                mcnt[i] <= 1;
            end
        end else begin
            if (redirect_e)           nxt = redirect_pc_e;
            else if (stall_f)         nxt = mpc;
            else if (model_pred(mpc)) nxt = mtgt[idx_of(mpc)];
            else                      nxt = mpc + 32'd4;
            mpc <= nxt;
            if (PRED && update_en_e) begin
                ui = idx_of(update_pc_e);
                if (mval[ui] && mtag[ui] == tag_of(update_pc_e)) begin
                    if (update_taken_e) mcnt[ui] <= (mcnt[ui] < 3) ? mcnt[ui] + 1 : 3;
                    else                mcnt[ui] <= (mcnt[ui] > 0) ? mcnt[ui] - 1 : 0;
                end else begin
                    mval[ui] <= 1'b1;
                    mtag[ui] <= tag_of(update_pc_e);
                    mcnt[ui] <= update_taken_e ? 2 : 1;
                end
                if (update_taken_e) mtgt[ui] <= update_target_e;
            end
        end
    end

    // Per-cycle comparison, 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        chk("cyc_pc_f",      pc_f,          mpc);
        chk("cyc_imem_addr", imem_addr,     mpc);
        chk("cyc_pc_plus4",  pc_plus4_f,    mpc + 32'd4);
        chk("cyc_instr",     instruction_f, mem_word(mpc));
        chk("cyc_pred",      {31'd0, predicted_branch_f}, {31'd0, rst && model_pred(mpc)});
        chk("cyc_flush",     {31'd0, flush_f}, {31'd0, redirect_e});
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        stall_f        = 1'b0;
        redirect_e     = 1'b0;
        update_en_e    = 1'b0;
        update_taken_e = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_e    = 1'b1;
        redirect_pc_e = a;
        step();
        redirect_e    = 1'b0;
    endtask

    task automatic train(input logic [31:0] p, input bit taken, input logic [31:0] t);
        update_en_e     = 1'b1;
        update_pc_e     = p;
        update_taken_e  = taken;
        update_target_e = t;
        step();
        update_en_e     = 1'b0;
    endtask

    function automatic logic [31:0] pick_pc(input int unsigned sel);
        case (sel % 8)
            0: return 32'h0000_0040;
            1: return 32'h0000_0440;
            2: return 32'h0000_0080;
            3: return 32'h0000_0100;
            4: return 32'hFFFF_FFFC;
            5: return 32'h0000_00C4;
            6: return $urandom & 32'h0000_0FFC;
            default: return $urandom & 32'h0000_03FF;
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        redirect_pc_e   = '0;
        update_pc_e     = '0;
        update_target_e = '0;

        // Reset state
        #12;
        chk("rst_pc_f",   pc_f,       RESET_PC);
        chk("rst_plus4",  pc_plus4_f, RESET_PC + 32'd4);
        chk("rst_pred",   {31'd0, predicted_branch_f}, 32'd0);
        chk("rst_flush",  {31'd0, flush_f}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Sequential fetch 0,4,8
        chk("seq_pc0", pc_f, 32'h0);
        step(); chk("seq_pc4", pc_f, 32'h4);
        step(); chk("seq_pc8", pc_f, 32'h8);

        // Stall for three cycles at 8, then resume at 12
        stall_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    pc_f,          32'h8);
            chk("stall_instr", instruction_f, mem_word(32'h8));
        end
        stall_f = 1'b0;
        step(); chk("resume_pc", pc_f, 32'hC);

        // Redirect beats stall; flush is combinational
        stall_f       = 1'b1;
        redirect_e    = 1'b1;
        redirect_pc_e = 32'h100;
        #1 chk("redir_flush", {31'd0, flush_f}, 32'd1);
        step();
        chk("redir_pc", pc_f, 32'h100);
        stall_f    = 1'b0;
        redirect_e = 1'b0;
        #1 chk("redir_flush_off", {31'd0, flush_f}, 32'd0);

        // Train 0x40 taken -> 0x80 (counter 10)
        train(32'h40, 1'b1, 32'h80);
        redirect_to(32'h40);
        chk("tr_pred", {31'd0, predicted_branch_f}, {31'd0, PRED});
        step();
        chk("tr_next", pc_f, PRED ? 32'h80 : 32'h44);

        // Two not-taken updates: 10 -> 01 -> 00
        train(32'h40, 1'b0, 32'h0);
        train(32'h40, 1'b0, 32'h0);
        redirect_to(32'h40);
        chk("nt_pred", {31'd0, predicted_branch_f}, 32'd0);
        step();
        chk("nt_next", pc_f, 32'h44);

        // Back to 10, then same-cycle NT update and fetch of 0x40
        train(32'h40, 1'b1, 32'h80);
        train(32'h40, 1'b1, 32'h80);
        redirect_to(32'h40);
        update_en_e     = 1'b1;
        update_pc_e     = 32'h40;
        update_taken_e  = 1'b0;
        update_target_e = 32'h0;
        #1 chk("same_pred", {31'd0, predicted_branch_f}, {31'd0, PRED});
        step();
        update_en_e = 1'b0;
        chk("same_next", pc_f, PRED ? 32'h80 : 32'h44);

        // Same index, other tag: miss
        train(32'h40, 1'b1, 32'h80);
        redirect_to(32'h440);
        chk("alias_pred", {31'd0, predicted_branch_f}, 32'd0);
        step();
        chk("alias_next", pc_f, 32'h444);

        // PC wrap-around
        redirect_to(32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4_f, 32'h0);
        step();
        chk("wrap_pc", pc_f, 32'h0);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            stall_f         = ($urandom % 4) == 0;
            redirect_e      = ($urandom % 10) == 0;
            redirect_pc_e   = pick_pc($urandom);
            update_en_e     = ($urandom % 3) == 0;
            update_pc_e     = pick_pc($urandom);
            update_taken_e  = $urandom % 2;
            update_target_e = pick_pc($urandom);
            if (n == 1500) begin
                #2 rst = 1'b0;
                #1;
                chk("arst_pc_f", pc_f, RESET_PC);
                chk("arst_pred", {31'd0, predicted_branch_f}, 32'd0);
                step();
                rst = 1'b1;
            end
            step();
        end

        idle();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
